// File: rtl/cacheline_adaptor_if.sv
// Bundle of the cacheline adaptor's bus signals.
//   Arbiter side : line_i, address_i, read_i, write_i -> ; <- line_o, resp_o
//   Memory side  : burst_i, resp_i -> ; <- burst_o, address_o, read_o, write_o
// The adaptor connects through the slave modport. The arbiter/memory
// environment connects through the master modport.
interface cacheline_adaptor_if;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  modport slave (
    input  line_i, address_i, read_i, write_i, burst_i, resp_i,
    output line_o, resp_o, burst_o, address_o, read_o, write_o
  );

  modport master (
    output line_i, address_i, read_i, write_i, burst_i, resp_i,
    input  line_o, resp_o, burst_o, address_o, read_o, write_o
  );
endinterface

// File: rtl/cacheline_adaptor.sv
// Cacheline adaptor: turns single-transfer 256-bit line requests from the
// arbiter into 4-beat 64-bit bursts toward physical memory, and assembles
// returned read beats into a full line.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous, active-high reset
//   bus  - cacheline_adaptor_if.slave (arbiter line side + memory burst side)
// Beat 0 carries line bits [63:0]; beat 3 carries [255:192].
module cacheline_adaptor (
  input  logic                  clk,
  input  logic                  rst,
  cacheline_adaptor_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t             state;
  logic [1:0]         cnt;
  logic [3:0][63:0]   rd_line;
  logic [3:0][63:0]   wr_line;
  logic [31:0]        address;
  logic               read_req;
  logic               write_req;
  logic               resp;

  assign bus.line_o    = rd_line;
  assign bus.address_o = address;
  assign bus.read_o    = read_req;
  assign bus.write_o   = write_req;
  assign bus.resp_o    = resp;
  // Write beat is selected straight from the beat counter so memory sees
  // the next beat in the same cycle cnt advances.
  assign bus.burst_o   = wr_line[cnt];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 2'd0;
      rd_line   <= '0;
      wr_line   <= '0;
      address   <= 32'd0;
      read_req  <= 1'b0;
      write_req <= 1'b0;
      resp      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          resp <= 1'b0;
          // Read has priority when both requests are present.
          if (bus.read_i) begin
            address  <= {bus.address_i[31:5], 5'b0};
            cnt      <= 2'd0;
            read_req <= 1'b1;
            state    <= READ;
          end else if (bus.write_i) begin
            address   <= {bus.address_i[31:5], 5'b0};
            cnt       <= 2'd0;
            wr_line   <= bus.line_i;
            write_req <= 1'b1;
            state     <= WRITE;
          end
        end
        READ: begin
          if (bus.resp_i) begin
            rd_line[cnt] <= bus.burst_i;
            cnt          <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              read_req <= 1'b0;
              resp     <= 1'b1;
              state    <= DONE;
            end
          end
        end
        WRITE: begin
          if (bus.resp_i) begin
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              write_req <= 1'b0;
              resp      <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          // Requests still held by the arbiter here are deliberately not
          // sampled; only IDLE may start a transaction.
          resp  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          read_req  <= 1'b0;
          write_req <= 1'b0;
          resp      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed testbench for cacheline_adaptor. The bench plays both the
// arbiter and the memory, driving inputs 1 time unit after each rising edge.
module tb_cacheline_adaptor;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  int   resp_cnt;
  int   wr_cycles;
  int   rd_starts;
  logic rd_prev;

  cacheline_adaptor_if bus ();

  cacheline_adaptor dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Activity counters sampled on the falling edge.
  initial begin
    resp_cnt  = 0;
    wr_cycles = 0;
    rd_starts = 0;
    rd_prev   = 1'b0;
  end
  always @(negedge clk) begin
    if (bus.resp_o)  resp_cnt  <= resp_cnt + 1;
    if (bus.write_o) wr_cycles <= wr_cycles + 1;
    if (bus.read_o && !rd_prev) rd_starts <= rd_starts + 1;
    rd_prev <= bus.read_o;
  end

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one cycle so it is sampled at the next edge.
  task automatic request(input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [255:0] line);
    bus.read_i    = rd;
    bus.write_i   = wr;
    bus.address_i = addr;
    bus.line_i    = line;
    tick();
  endtask

  // Memory side: pat[i]=='1' strobes resp_i in cycle i. Read beats come from
  // 'line'; write beats are checked against 'line'.
  task automatic burst(input logic is_read, input logic [255:0] line, input string pat);
    int k;
    k = 0;
    for (int i = 0; i < pat.len(); i++) begin
      bus.resp_i  = (pat[i] == "1");
      bus.burst_i = (bus.resp_i && k < 4) ? line[64*k +: 64] : 64'hdead_beef_dead_beef;
      #1;
      chk(is_read ? "read_o_held" : "write_o_held",
          is_read ? bus.read_o : bus.write_o, 1'b1);
      if (!is_read && bus.resp_i)
        chk($sformatf("wbeat%0d", k), bus.burst_o, line[64*k +: 64]);
      if (bus.resp_i) k = k + 1;
      @(posedge clk);
      #1;
    end
    bus.resp_i  = 1'b0;
    bus.burst_i = 64'd0;
  endtask

  logic [255:0] l1, w1, l2, l3, l4, l5, l6, l7;
  int           r0, s0, w0;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    l1 = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    w1 = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
    l2 = {64'h0123_4567_89ab_cdef, 64'hfedc_ba98_7654_3210, 64'h5555_aaaa_5555_aaaa, 64'h0f0f_f0f0_0f0f_f0f0};
    l3 = {64'h3333_0000_0000_0003, 64'h3333_0000_0000_0002, 64'h3333_0000_0000_0001, 64'h3333_0000_0000_0000};
    l4 = {64'h4444_0000_0000_0003, 64'h4444_0000_0000_0002, 64'h4444_0000_0000_0001, 64'h4444_0000_0000_0000};
    l5 = {64'h5555_0000_0000_0003, 64'h5555_0000_0000_0002, 64'h5555_0000_0000_0001, 64'h5555_0000_0000_0000};
    l6 = {64'h6666_0000_0000_0003, 64'h6666_0000_0000_0002, 64'h6666_0000_0000_0001, 64'h6666_0000_0000_0000};
    l7 = {64'h7777_0000_0000_0003, 64'h7777_0000_0000_0002, 64'h7777_0000_0000_0001, 64'h7777_0000_0000_0000};

    rst           = 1'b1;
    bus.line_i    = '0;
    bus.address_i = 32'd0;
    bus.read_i    = 1'b0;
    bus.write_i   = 1'b0;
    bus.burst_i   = 64'd0;
    bus.resp_i    = 1'b0;
    tick();
    tick();

    chk("rst_line_o",    bus.line_o,    256'd0);
    chk("rst_burst_o",   bus.burst_o,   64'd0);
    chk("rst_address_o", bus.address_o, 32'd0);
    chk("rst_read_o",    bus.read_o,    1'b0);
    chk("rst_write_o",   bus.write_o,   1'b0);
    chk("rst_resp_o",    bus.resp_o,    1'b0);
    rst = 1'b0;
    tick();

    // Read, no gaps
    r0 = resp_cnt;
    request(1'b1, 1'b0, 32'h0000_1234, '0);
    bus.read_i = 1'b0;
    chk("rd1_address_o", bus.address_o, 32'h0000_1220);
    chk("rd1_read_o",    bus.read_o,    1'b1);
    burst(1'b1, l1, "1111");
    chk("rd1_resp_o",    bus.resp_o,    1'b1);
    chk("rd1_read_done", bus.read_o,    1'b0);
    chk("rd1_line_o",    bus.line_o,    l1);
    tick();
    chk("rd1_resp_low",  bus.resp_o,    1'b0);
    chk("rd1_resp_cnt",  resp_cnt - r0, 1);

    // Write with gaps; line_i changes after latch must be ignored
    r0 = resp_cnt;
    request(1'b0, 1'b1, 32'h0000_2468, w1);
    bus.write_i = 1'b0;
    bus.line_i  = {256{1'b1}};
    chk("wr_write_o",   bus.write_o,   1'b1);
    chk("wr_address_o", bus.address_o, 32'h0000_2460);
    burst(1'b0, w1, "101101");
    chk("wr_resp_o",    bus.resp_o,    1'b1);
    chk("wr_write_done", bus.write_o,  1'b0);
    chk("wr_line_kept", bus.line_o,    l1);
    tick();
    chk("wr_resp_cnt",  resp_cnt - r0, 1);

    // Simultaneous read and write: read wins
    w0 = wr_cycles;
    request(1'b1, 1'b1, 32'h0000_2000, w1);
    bus.read_i  = 1'b0;
    bus.write_i = 1'b0;
    chk("both_read_o",  bus.read_o,  1'b1);
    chk("both_write_o", bus.write_o, 1'b0);
    burst(1'b1, l2, "1111");
    chk("both_line_o",  bus.line_o,  l2);
    tick();
    chk("both_no_write", wr_cycles - w0, 0);

    // Held request through DONE
    r0 = resp_cnt;
    s0 = rd_starts;
    request(1'b1, 1'b0, 32'h0000_3000, '0);
    burst(1'b1, l3, "1111");
    chk("held_resp_o", bus.resp_o, 1'b1);
    tick();
    chk("held_read_o_idle", bus.read_o, 1'b0);
    bus.read_i = 1'b0;
    tick();
    tick();
    tick();
    chk("held_read_o_after", bus.read_o, 1'b0);
    chk("held_bursts",  rd_starts - s0, 1);
    chk("held_resps",   resp_cnt - r0,  1);
    chk("held_line_o",  bus.line_o,     l3);

    // Back-to-back reads
    request(1'b1, 1'b0, 32'h0000_0100, '0);
    bus.read_i = 1'b0;
    chk("b2b1_address_o", bus.address_o, 32'h0000_0100);
    burst(1'b1, l4, "1111");
    chk("b2b1_resp_o",  bus.resp_o, 1'b1);
    chk("b2b1_line_o",  bus.line_o, l4);
    tick();
    request(1'b1, 1'b0, 32'h0000_0120, '0);
    bus.read_i = 1'b0;
    chk("b2b2_address_o", bus.address_o, 32'h0000_0120);
    chk("b2b2_read_o",    bus.read_o,    1'b1);
    chk("b2b2_line_held", bus.line_o,    l4);
    burst(1'b1, l5, "0");
    chk("b2b2_line_gap",  bus.line_o,    l4);
    burst(1'b1, l5, "1111");
    chk("b2b2_resp_o",  bus.resp_o, 1'b1);
    chk("b2b2_line_o",  bus.line_o, l5);
    tick();

    // Async reset mid-read after beat 2
    request(1'b1, 1'b0, 32'h0000_4000, '0);
    bus.read_i = 1'b0;
    burst(1'b1, l6, "11");
    r0 = resp_cnt;
    rst = 1'b1;
    #1;
    chk("arst_read_o",    bus.read_o,    1'b0);
    chk("arst_address_o", bus.address_o, 32'd0);
    chk("arst_line_o",    bus.line_o,    256'd0);
    chk("arst_burst_o",   bus.burst_o,   64'd0);
    chk("arst_write_o",   bus.write_o,   1'b0);
    chk("arst_resp_o",    bus.resp_o,    1'b0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("arst_no_resp",   resp_cnt - r0, 0);
    chk("arst_idle_read", bus.read_o,    1'b0);

    request(1'b1, 1'b0, 32'h0000_5010, '0);
    bus.read_i = 1'b0;
    chk("post_address_o", bus.address_o, 32'h0000_5000);
    burst(1'b1, l7, "1111");
    chk("post_resp_o", bus.resp_o, 1'b1);
    chk("post_line_o", bus.line_o, l7);
    tick();
    chk("post_resp_low", bus.resp_o, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
